// File: rtl/cpu_step_ctrl_pkg.sv
// cpu_step_pkg: shared constants and types for the CPU clock-enable controller.
//   state_e    - controller state encoding, also driven onto the 2-bit state output
//   DIV_W      - width of the free-running divider
//   CNT_W      - width of the issued-enable counter
//   tick_mask  - low-bit mask selecting the divider bits that must all be ones for a tick
package cpu_step_pkg;

  localparam int DIV_W = 32;
  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    ST_HALT      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STEP      = 2'd2,
    ST_STEP_WAIT = 2'd3
  } state_e;

  function automatic logic [DIV_W-1:0] tick_mask(input logic [4:0] log2);
    tick_mask = (DIV_W'(1) << log2) - DIV_W'(1);
  endfunction

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// cpu_step_ctrl_if: control and status bundle between the lab SoC and cpu_step_ctrl.
//   mode_run  - run switch (asynchronous)
//   sel_slow  - rate switch (asynchronous), 1 = slow rate
//   step_btn  - raw single-step push-button
//   halt_req  - synchronous halt pulse from the CPU
//   cpu_en    - one-cycle CPU enable
//   state     - current controller state
//   en_count  - number of enables issued, wraps
// master drives the requests and observes status; slave is the controller side.
interface cpu_step_ctrl_if;
  import cpu_step_pkg::*;

  logic             mode_run;
  logic             sel_slow;
  logic             step_btn;
  logic             halt_req;
  logic             cpu_en;
  logic [1:0]       state;
  logic [CNT_W-1:0] en_count;

  modport master (
    output mode_run, sel_slow, step_btn, halt_req,
    input  cpu_en, state, en_count
  );

  modport slave (
    input  mode_run, sel_slow, step_btn, halt_req,
    output cpu_en, state, en_count
  );

endinterface

// File: rtl/cpu_step_ctrl_btn_debounce.sv
// btn_debounce: synchronizes a raw push-button, debounces it and produces a
// registered one-cycle pulse on each accepted press.
//   clk, rst  - clock and asynchronous active-high reset
//   i_btn     - raw, bouncing button input
//   o_level   - debounced level
//   o_rise    - one-cycle pulse, the cycle after the debounced level goes 0->1
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LP_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic          r_db_d;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  // The level flips only after DEBOUNCE_CYCLES consecutive disagreeing
  // samples; a single agreeing sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_db_d  <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == LP_LAST) begin
        r_db  <= ~r_db;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_db_d <= r_db;
      r_rise <= r_db & ~r_db_d;
    end
  end

  assign o_level = r_db;
  assign o_rise  = r_rise;

endmodule

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: single-clock-domain CPU enable generator. Runs the CPU at a
// fast or slow divided rate, halts on request, and single-steps from a
// debounced push-button.
//   clk, rst  - system clock and asynchronous active-high reset
//   bus       - cpu_step_ctrl_if slave: switches, button, halt request in;
//               cpu_en, state, en_count out
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_HALT      | CPU stopped; waits for a run-switch rising edge or a step
// ST_RUN       | free-run; cpu_en follows divider ticks
// ST_STEP      | the single cpu_en cycle of a step
// ST_STEP_WAIT | step issued; waits for the button to be released
module cpu_step_ctrl
  import cpu_step_pkg::*;
#(
  parameter int DIV_FAST_LOG2   = 2,
  parameter int DIV_SLOW_LOG2   = 24,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  cpu_step_ctrl_if.slave    bus
);

  logic             r_run_s1;
  logic             r_run_s2;
  logic             r_run_prev;
  logic [1:0]       r_sync_fill;
  logic             r_sel_s1;
  logic             r_sel_s2;
  logic [DIV_W-1:0] r_div;
  state_e           r_state;
  logic             r_cpu_en;
  logic [CNT_W-1:0] r_en_count;

  state_e           w_state_nxt;
  logic             w_en_nxt;
  logic             w_tick;
  logic             w_run_rise;
  logic             w_db;
  logic             w_step_rise;
  logic [4:0]       w_log2;
  logic [DIV_W-1:0] w_mask;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_db (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (bus.step_btn),
    .o_level (w_db),
    .o_rise  (w_step_rise)
  );

  // The synchronizer restarts from 0 after reset, so its output is not a real
  // observation of the switch until both stages have been loaded. The previous
  // value is held at 1 until then; a switch left on through reset must not
  // look like a fresh rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_s1    <= 1'b0;
      r_run_s2    <= 1'b0;
      r_run_prev  <= 1'b1;
      r_sync_fill <= 2'b00;
      r_sel_s1    <= 1'b0;
      r_sel_s2    <= 1'b0;
    end else begin
      r_run_s1    <= bus.mode_run;
      r_run_s2    <= r_run_s1;
      r_sync_fill <= {r_sync_fill[0], 1'b1};
      if (r_sync_fill[1]) begin
        r_run_prev <= r_run_s2;
      end
      r_sel_s1    <= bus.sel_slow;
      r_sel_s2    <= r_sel_s1;
    end
  end

  assign w_run_rise = r_run_s2 & ~r_run_prev;

  // The divider is never cleared on a rate change, so the new rate simply
  // takes over at its next naturally aligned tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign w_log2 = r_sel_s2 ? 5'(DIV_SLOW_LOG2) : 5'(DIV_FAST_LOG2);
  assign w_mask = tick_mask(w_log2);
  assign w_tick = ((r_div & w_mask) == w_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_HALT;
      r_cpu_en   <= 1'b0;
      r_en_count <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cpu_en <= w_en_nxt;
      if (w_en_nxt) begin
        r_en_count <= r_en_count + CNT_W'(1);
      end
    end
  end

  // Halt conditions are tested before the tick so a coincident halt or
  // run-switch drop suppresses the enable.
  always_comb begin
    w_state_nxt = r_state;
    w_en_nxt    = 1'b0;
    case (r_state)
      ST_HALT: begin
        if (w_run_rise) begin
          w_state_nxt = ST_RUN;
        end else if (w_step_rise) begin
          w_state_nxt = ST_STEP;
          w_en_nxt    = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.halt_req || !r_run_s2) begin
          w_state_nxt = ST_HALT;
        end else if (w_tick) begin
          w_en_nxt = 1'b1;
        end
      end
      ST_STEP: begin
        w_state_nxt = ST_STEP_WAIT;
      end
      ST_STEP_WAIT: begin
        if (!w_db) begin
          w_state_nxt = ST_HALT;
        end
      end
      default: begin
        w_state_nxt = ST_HALT;
      end
    endcase
  end

  assign bus.cpu_en   = r_cpu_en;
  assign bus.state    = r_state;
  assign bus.en_count = r_en_count;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
module tb_cpu_step_ctrl;

  localparam int FAST = 2;
  localparam int SLOW = 4;
  localparam int DB   = 4;

  localparam int M_HALT      = 0;
  localparam int M_RUN       = 1;
  localparam int M_STEP      = 2;
  localparam int M_STEP_WAIT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cpu_step_ctrl_if bus();

  cpu_step_ctrl #(
    .DIV_FAST_LOG2   (FAST),
    .DIV_SLOW_LOG2   (SLOW),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  bit          chk_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: switches are seen two edges late, the divider is
  // simply "cycles since reset", the debounced level flips after DB
  // consecutive disagreeing synced samples, and the controller follows the
  // written state rules.
  bit          m_run_s1 = 0, m_run_s2 = 0, m_run_prev = 1;
  bit          m_sel_s1 = 0, m_sel_s2 = 0;
  bit          m_btn_s1 = 0, m_btn_s2 = 0;
  bit          m_db = 0, m_db_rose = 0, m_rise = 0, m_en = 0;
  int          m_dis = 0, m_state = M_HALT, m_age = 0;
  int unsigned m_div = 0, m_cnt = 0;

  task automatic m_reset();
    m_run_s1 = 0; m_run_s2 = 0; m_run_prev = 1;
    m_sel_s1 = 0; m_sel_s2 = 0;
    m_btn_s1 = 0; m_btn_s2 = 0;
    m_db = 0; m_db_rose = 0; m_rise = 0; m_en = 0;
    m_dis = 0; m_state = M_HALT; m_age = 0;
    m_div = 0; m_cnt = 0;
  endtask

  task automatic m_step();
    int    n, nst, dis_n;
    longint p;
    bit    tick, run_rise, en, db_n;
    n        = m_sel_s2 ? SLOW : FAST;
    p        = longint'(1) << n;
    tick     = ((longint'(m_div) % p) == p - 1);
    run_rise = m_run_s2 && !m_run_prev;
    en       = 0;
    nst      = m_state;
    case (m_state)
      M_HALT:  if (run_rise) nst = M_RUN;
               else if (m_rise) begin nst = M_STEP; en = 1; end
      M_RUN:   if (bus.halt_req || !m_run_s2) nst = M_HALT;
               else if (tick) en = 1;
      M_STEP:  nst = M_STEP_WAIT;
      default: if (!m_db) nst = M_HALT;
    endcase
    db_n  = m_db;
    dis_n = 0;
    if (m_btn_s2 != m_db) begin
      dis_n = m_dis + 1;
      if (dis_n == DB) begin
        db_n  = !m_db;
        dis_n = 0;
      end
    end
    m_rise    = m_db_rose;
    m_db_rose = db_n && !m_db;
    m_db      = db_n;
    m_dis     = dis_n;
    if (m_age >= 2) m_run_prev = m_run_s2;
    if (m_age < 10) m_age++;
    m_run_s2 = m_run_s1; m_run_s1 = bus.mode_run;
    m_sel_s2 = m_sel_s1; m_sel_s1 = bus.sel_slow;
    m_btn_s2 = m_btn_s1; m_btn_s1 = bus.step_btn;
    m_div++;
    m_state = nst;
    m_en    = en;
    if (en) m_cnt++;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) m_reset();
    else     m_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cpu_en", bus.cpu_en, m_en);
      check("state", bus.state, m_state);
      check("en_count", bus.en_count, m_cnt);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_en(input string tag, input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (bus.cpu_en === 1'b1) begin
        at = int'(cyc);
        break;
      end
    end
    check({tag, "_timeout"}, (at < 0), 0);
  endtask

  task automatic wait_state(input string tag, input int st, input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (bus.state === 2'(st)) begin
        at = int'(cyc);
        break;
      end
    end
    check({tag, "_timeout"}, (at < 0), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int c0, c1, c2, c3, bad, gap, prev;
    logic [31:0] cnt0, cnt1;
    bit level;
    int bounce;

    bus.mode_run = 1'b1;
    bus.sel_slow = 1'b0;
    bus.step_btn = 1'b0;
    bus.halt_req = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk_en = 1'b1;

    // switch on through reset: no start
    @(negedge clk);
    check("reset_state", bus.state, M_HALT);
    check("reset_count", bus.en_count, 0);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.state !== 2'd0 || bus.cpu_en !== 1'b0) bad++;
    end
    check("run_on_through_reset", bad, 0);

    // 0->1 toggle: RUN three cycles after the rise
    nxt(); bus.mode_run = 1'b0;
    repeat (6) nxt();
    bus.mode_run = 1'b1;
    c0 = int'(cyc);
    wait_state("run_entry", M_RUN, 20, c1);
    check("run_latency", c1 - c0, 3);

    // fast rate
    wait_en("fast_a", 20, c1); cnt0 = bus.en_count;
    wait_en("fast_b", 20, c2); cnt1 = bus.en_count;
    check("fast_period", c2 - c1, 4);
    check("fast_count_step", cnt1 - cnt0, 1);

    // slow rate
    nxt(); bus.sel_slow = 1'b1;
    repeat (40) nxt();
    wait_en("slow_a", 40, c1);
    wait_en("slow_b", 40, c2);
    wait_en("slow_c", 40, c3);
    check("slow_period_1", c2 - c1, 16);
    check("slow_period_2", c3 - c2, 16);

    // halt coincident with the tick that precedes the next pulse
    cnt0 = bus.en_count;
    repeat (15) @(posedge clk);
    #2 bus.halt_req = 1'b1;
    nxt(); bus.halt_req = 1'b0;
    @(negedge clk);
    check("halt_tick_en", bus.cpu_en, 0);
    check("halt_tick_state", bus.state, M_HALT);
    check("halt_tick_count", bus.en_count, cnt0);

    // bouncing press from HALT
    for (int i = 0; i < 6; i++) begin
      nxt(); bus.step_btn = (i % 2 == 0);
    end
    nxt(); bus.step_btn = 1'b1;
    c0 = int'(cyc);
    cnt0 = bus.en_count;
    wait_en("step_en", 30, c1);
    check("step_latency", c1 - c0, 8);
    check("step_in_step", bus.state, M_STEP);
    @(negedge clk);
    check("step_in_wait", bus.state, M_STEP_WAIT);
    while (int'(cyc) < c0 + 20) nxt();
    check("step_single_pulse", bus.en_count - cnt0, 1);
    bus.step_btn = 1'b0;
    c2 = int'(cyc);
    wait_state("step_release", M_HALT, 20, c3);
    check("release_latency", c3 - c2, 7);

    // step press while running changes nothing
    nxt(); bus.mode_run = 1'b0; bus.sel_slow = 1'b0;
    repeat (6) nxt();
    bus.mode_run = 1'b1;
    wait_state("run2_entry", M_RUN, 20, c0);
    wait_en("run2_first", 20, prev);
    nxt(); bus.step_btn = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 6) begin nxt(); bus.step_btn = 1'b0; end
      wait_en("run2_pulse", 20, c1);
      gap = c1 - prev;
      if (gap != 4) bad++;
      prev = c1;
    end
    check("run_step_gaps", bad, 0);
    check("run_step_state", bus.state, M_RUN);

    // reset while in STEP
    nxt(); bus.mode_run = 1'b0;
    repeat (12) nxt();
    bus.step_btn = 1'b1;
    wait_state("mid_step", M_STEP, 30, c0);
    #2 rst = 1'b1;
    #1;
    check("rst_step_en", bus.cpu_en, 0);
    check("rst_step_state", bus.state, M_HALT);
    check("rst_step_count", bus.en_count, 0);
    bus.step_btn = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // en_count wrap
    repeat (6) nxt();
    bus.mode_run = 1'b1;
    wait_state("run3_entry", M_RUN, 20, c0);
    wait_en("wrap_a", 20, c1);
    nxt();
    force dut.r_en_count = 32'hFFFF_FFFF;
    release dut.r_en_count;
    m_cnt = 32'hFFFF_FFFF;
    wait_en("wrap_b", 20, c2);
    check("wrap_period", c2 - c1, 4);
    check("wrap_count", bus.en_count, 0);

    // randomized traffic against the reference
    level  = 1'b0;
    bounce = 0;
    for (int i = 0; i < 3000; i++) begin
      nxt();
      if (i == 1500) rst = 1'b1;
      if (i == 1502) rst = 1'b0;
      bus.halt_req = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 59) == 0) bus.mode_run = ~bus.mode_run;
      if ($urandom_range(0, 199) == 0) bus.sel_slow = ~bus.sel_slow;
      if (bounce > 0) begin
        bounce--;
        bus.step_btn = (bounce == 0) ? level : 1'($urandom_range(0, 1));
      end else if ($urandom_range(0, 39) == 0) begin
        level  = ~level;
        bounce = $urandom_range(0, 4);
        bus.step_btn = (bounce == 0) ? level : 1'($urandom_range(0, 1));
      end
    end
    bus.halt_req = 1'b0;
    repeat (4) nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_step_ctrl.md
# cpu_step_ctrl

CPU clock-enable controller for the lab SoC. It replaces a switch-selected divided clock with a single-clock-domain enable, `cpu_en`. The CPU and its peripherals stay on `clk` and advance only on `cpu_en` cycles. The block runs the CPU at a fast or slow rate, halts it on request, and single-steps it from a debounced push-button.

## Interface
- `DIV_FAST_LOG2`, default 2: fast tick period is 2^DIV_FAST_LOG2 clk cycles; legal range 1..31.
- `DIV_SLOW_LOG2`, default 24: slow tick period is 2^DIV_SLOW_LOG2 clk cycles; legal range 1..31.
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles the synchronized step button must stay stable before it is accepted; must be ≥1.
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset; asynchronous, active-high.
- `mode_run`, in, 1: run switch, asynchronous; a rising edge starts free-run.
- `sel_slow`, in, 1: rate switch, asynchronous; 1 selects the slow rate, 0 the fast rate.
- `step_btn`, in, 1: single-step push-button, raw and bouncing.
- `halt_req`, in, 1: synchronous halt pulse from the CPU (e.g. a breakpoint).
- `cpu_en`, out, 1: registered one-cycle enable for the CPU.
- `state`, out, 2: current state; HALT=0, RUN=1, STEP=2, STEP_WAIT=3.
- `en_count`, out, 32: number of `cpu_en` pulses issued; wraps modulo 2^32.

## Operation
**Synchronizers and edge detection**
- `mode_run`, `sel_slow` and `step_btn` each pass through a 2-flop synchronizer; the sync flops reset to 0.
- The mode_run edge detector's previous-value register resets to 1. A switch already on at reset therefore does not start the CPU.

**Divider and ticks**
- A free-running 32-bit counter `div` resets to 0 and increments every cycle.
- `tick` is high when the low N bits of `div` are all ones. N is DIV_SLOW_LOG2 if synced `sel_slow`=1, otherwise DIV_FAST_LOG2.
- A rate change takes effect at the next tick of the new rate; `div` is never cleared on a rate change.

**Debouncer**
- `db` resets to 0.
- It toggles once synced `step_btn` has differed from `db` for DEBOUNCE_CYCLES consecutive cycles.
- Any agreement between synced `step_btn` and `db` clears the debounce count.
- `step_rise` is a one-cycle pulse on a 0→1 change of `db`.

**State machine** (registered; reset state HALT)
- HALT:
  - A `mode_run` rising edge → RUN.
  - Otherwise `step_rise` → STEP.
- RUN:
  - `halt_req`=1 or synced `mode_run`=0 → HALT.
  - Otherwise, on `tick`, `cpu_en` pulses in the next cycle.
- STEP: `cpu_en`=1 for exactly one cycle, then → STEP_WAIT unconditionally.
- STEP_WAIT: `db`=0 → HALT. One step is issued per press; holding the button never repeats.

**Output and event rules**
- `cpu_en` is registered. It is 1 only in the cycle after a RUN-state tick that was not overridden, or in the single STEP cycle.
- `en_count` increments in the same cycle `cpu_en`=1.
- `step_rise` in RUN, STEP or STEP_WAIT is ignored.
- A `mode_run` edge in STEP or STEP_WAIT is ignored. It is not remembered; a new edge is needed from HALT.
- `halt_req` and `tick` in the same cycle: halt wins and no `cpu_en` is issued.
- `mode_run` falling and `tick` in the same cycle: HALT wins and no `cpu_en` is issued.
- After a `halt_req`, staying in HALT requires no action. Restart needs `mode_run` 1→0→1.

**Reset** (asynchronous, any time, including mid-step)
- `cpu_en`=0, `en_count`=0, `state`=HALT, `div`=0, `db`=0, debounce count 0.

## Timing
- Tick to `cpu_en`: 1 cycle.
- RUN at a constant rate: `cpu_en` period is exactly 2^N cycles, duty is 1 cycle.
- `halt_req` sampled in cycle t: no `cpu_en` in cycle t+1 or later; `state`=HALT in cycle t+1.
- `mode_run` raw rise to `state`=RUN: 3 cycles (2 sync + 1 state register).
- Clean `step_btn` press to `cpu_en`: DEBOUNCE_CYCLES+4 cycles (2 sync, debounce, 1 edge, 1 state).

## Structure
- Package `cpu_step_pkg` holds:
  - the state encoding constants (HALT/RUN/STEP/STEP_WAIT);
  - the width constants `DIV_W=32` and `CNT_W=32`.
- Sub-module `btn_debounce`:
  - contains the synchronizer, the DEBOUNCE_CYCLES counter and the rise pulse;
  - is instantiated once, for `step_btn`.
- Everything else sits in `cpu_step_ctrl`.

## Test plan
All scenarios use DIV_FAST_LOG2=2, DIV_SLOW_LOG2=4 and DEBOUNCE_CYCLES=4.
- **Reset with run switch on:** `mode_run` held at 1 through reset release.
  - Required: `state` stays HALT and `cpu_en` stays 0 for 100 cycles.
  - Then toggle `mode_run` 0→1: `state`=RUN 3 cycles after the rise.
- **Fast run, then slow:** in RUN with `sel_slow`=0, `cpu_en` pulses every 4 cycles and `en_count` increments by 1 per pulse.
  - Set `sel_slow`=1: after the switch-over, pulses are every 16 cycles.
- **Halt on tick:** `halt_req` pulse coincident with a tick.
  - Required: no `cpu_en` in the next cycle, `state`=HALT, `en_count` unchanged.
- **Bouncing step press:** `step_btn` toggles with 1-cycle bounce for 6 cycles, then is held high for 20 cycles.
  - Required: exactly one `cpu_en`, 8 cycles after the stable level begins; `state` passes through STEP then STEP_WAIT.
  - Required: `state` returns to HALT 7 cycles after release.
- **Step ignored in RUN:** a step press while in RUN produces no extra `cpu_en` and the pulse period is unchanged.
- **Reset mid-step and wrap:**
  - `rst` asserted while in STEP: next cycle `cpu_en`=0 and `state`=HALT.
  - Force `en_count`=32'hFFFF_FFFF, then issue one pulse: `en_count`=0.
